// File: rtl/mem_stage.sv
// mem_stage: Y86-64 memory stage with multi-cycle data memory; define MEM_ALIGN_CHECK_EN to reject unaligned accesses
module mem_stage #(
  parameter int MEM_BYTES = 1024,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  e_icode,
  input  logic [2:0]  e_stat,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic        M_bubble,
  output logic        m_stall,
  output logic [2:0]  m_stat,
  output logic [63:0] m_valM,
  output logic [3:0]  M_icode,
  output logic [63:0] M_valE,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [3:0]  W_icode,
  output logic [2:0]  W_stat,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = $clog2(MEM_LAT) + 1;
  localparam logic [3:0] NOP = 4'h1;
  localparam logic [3:0] NONE = 4'hF;
  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] ADR = 3'd3;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] M_stat;
  logic [63:0] M_valA;
  logic [7:0] mem [MEM_BYTES];
  logic is_wr, is_rd, addr_ok, valid, we;
  logic [63:0] addr, rd_data;
  logic [AW-1:0] base;
  // M register: a bubble request wins over a stall, otherwise load unless held
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      M_icode <= NOP;
      M_stat  <= AOK;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= NONE;
      M_dstM  <= NONE;
    end else if (M_bubble) begin
      M_icode <= NOP;
      M_stat  <= AOK;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= NONE;
      M_dstM  <= NONE;
    end else if (!m_stall) begin
      M_icode <= e_icode;
      M_stat  <= e_stat;
      M_valE  <= e_valE;
      M_valA  <= e_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= e_dstM;
    end
  assign is_wr = M_icode inside {4'h4, 4'hA, 4'h8};
  assign is_rd = M_icode inside {4'h5, 4'hB, 4'h9};
  assign addr = (M_icode == 4'hB || M_icode == 4'h9) ? M_valA : M_valE;
`ifdef MEM_ALIGN_CHECK_EN
  assign addr_ok = ({1'b0, addr} + 65'd7 < 65'(MEM_BYTES)) && addr[2:0] == 3'd0;
`else
  assign addr_ok = {1'b0, addr} + 65'd7 < 65'(MEM_BYTES);
`endif
  assign valid = (is_wr || is_rd) && M_stat == AOK && addr_ok;
  assign m_stat = (is_wr || is_rd) && M_stat == AOK && !addr_ok ? ADR : M_stat;
  assign base = addr[AW-1:0];
  assign we = valid && is_wr && !m_stall && !(M_bubble && state == WAIT);
  assign m_valM = valid && is_rd ? rd_data : '0;
  // 8-byte little-endian read straight from the array
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 8; i++) rd_data[8*i +: 8] = mem[base + i[AW-1:0]];
  end
  // write commits once, at the edge closing the completion cycle
  always_ff @(posedge clk)
    if (we) for (int i = 0; i < 8; i++) mem[base + i[AW-1:0]] <= M_valA[8*i +: 8];
  // access FSM state and latency counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  // stall for MEM_LAT-1 cycles per valid access; a bubble aborts the access
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    m_stall = 1'b0;
    if (state == IDLE) begin
      if (valid && MEM_LAT > 1) begin
        m_stall = 1'b1;
        state_n = WAIT;
        cnt_n = CW'(1);
      end
    end else if (cnt < CW'(MEM_LAT - 1)) begin
      m_stall = 1'b1;
      cnt_n = cnt + CW'(1);
    end else begin
      state_n = IDLE;
      cnt_n = '0;
    end
    if (M_bubble) begin
      state_n = IDLE;
      cnt_n = '0;
    end
  end
  // W register: bubble while stalled so writeback never sees an access twice
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || m_stall) begin
      W_icode <= NOP;
      W_stat  <= AOK;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= NONE;
      W_dstM  <= NONE;
    end else begin
      W_icode <= M_icode;
      W_stat  <= m_stat;
      W_valE  <= M_valE;
      W_valM  <= m_valM;
      W_dstE  <= M_dstE;
      W_dstM  <= M_dstM;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the five-stage Y86-64 pipeline. Consumes the execute stage outputs (e_icode, e_valE, e_valA, e_dstE, e_dstM) through the M pipeline register.
- Performs data-memory reads and writes with a fixed multi-cycle access latency, and stalls the pipeline while an access is in flight.
- Drives the W pipeline register plus the m_* forwarding signals.

Parameters:
- MEM_BYTES, 1024, size of the internal byte-addressed data memory.
- MEM_LAT, 2, cycles per data-memory access (≥1).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- e_icode  in  4  instruction code from execute
- e_stat  in  3  status from execute (1 AOK, 2 HLT, 3 ADR, 4 INS)
- e_valE  in  64  ALU result from execute
- e_valA  in  64  valA or valP from execute
- e_dstE  in  4  destination E from execute (4'hF = none)
- e_dstM  in  4  destination M from execute
- M_bubble  in  1  pipeline-control request to load a bubble into M
- m_stall  out  1  memory access in progress; upstream must hold
- m_stat  out  3  status after memory access
- m_valM  out  64  read data, forwarding path
- M_icode  out  4  registered M-stage icode
- M_valE  out  64  registered valE, forwarding path
- M_dstE  out  4  registered dstE
- M_dstM  out  4  registered dstM
- W_icode  out  4  W register icode
- W_stat  out  3  W register status
- W_valE  out  64  W register valE
- W_valM  out  64  W register valM
- W_dstE  out  4  W register dstE
- W_dstM  out  4  W register dstM

Behaviour:

Reset (rst_n low, asynchronous):
- M and W registers load bubble values: icode 4'h1 (nop), stat 1, dstE/dstM 4'hF, valE/valA/valM 0.
- FSM goes to IDLE and the counter clears.
- Memory contents are not reset.

M register, on posedge clk:
- If M_bubble is high, load bubble values. M_bubble has priority over stall.
- Else if m_stall is low, capture the e_* inputs.
- Else hold.

Access decode (from M_icode):
- Write address M_valE, data M_valA: rmmovq 4, pushq A, call 8.
- Read address M_valE: mrmovq 5.
- Read address M_valA: popq B, ret 9.
- All other icodes perform no access.
- Memory is 8-byte little-endian: address holds bits 7:0.

Valid access:
- Requires M_stat == 1 and addr+7 < MEM_BYTES.
- Address compare is done in 65 bits, so wrap-around counts as out of range.

Invalid address:
- No write is performed and m_valM = 0.
- m_stat = 3; otherwise m_stat = M_stat.
- No stall.

FSM states IDLE and WAIT, with counter cnt of width clog2(MEM_LAT)+1:
- IDLE: if there is a valid access and MEM_LAT > 1, assert m_stall, go to WAIT, cnt = 1.
- WAIT: m_stall stays high while cnt < MEM_LAT-1, and cnt increments. When cnt == MEM_LAT-1, m_stall drops and the state returns to IDLE.
- Net effect: m_stall is high for exactly MEM_LAT-1 cycles per access. When MEM_LAT = 1, m_stall is never asserted.

Completion cycle (m_stall low with a valid access):
- m_valM holds the read data combinationally from the array.
- A write commits at the closing clock edge, and commits exactly once.

W register, on posedge clk:
- If m_stall is high, load a W bubble, so writeback never sees duplicates.
- Otherwise capture M_icode, m_stat, M_valE, m_valM, M_dstE, M_dstM.

Boundary cases:
- M_bubble during WAIT aborts the access: no write, FSM returns to IDLE.
- Reset mid-access aborts the access: no write.
- A non-AOK M_stat (HLT/INS/ADR) suppresses both the access and the stall.

Optional Feature:
MEM_ALIGN_CHECK_EN:
- Defined: a read or write with addr[2:0] != 0 is treated as an invalid address (m_stat = 3, no write, m_valM = 0, no stall).
- Undefined: unaligned 8-byte accesses are permitted and fully byte-addressed.

Test Plan:
1. MEM_LAT = 2; rmmovq writes 64'h1122334455667788 at 0x40, followed by mrmovq reading 0x40. Required: m_stall high one cycle per access; W_valM = 64'h1122334455667788; byte 0x40 = 8'h88.
2. pushq with valE = 0x100, valA = 5, then popq with valA = 0x100. Required: W_valM = 5; W_valE passes through unchanged; a W bubble appears during each stall cycle.
3. mrmovq at valE = 1020 with MEM_BYTES = 1024. Required: m_stat = 3, W_stat = 3, no stall. Then a write at valE = 64'hFFFFFFFFFFFFFFFC must leave memory unchanged.
4. M_bubble asserted during the WAIT of an rmmovq to 0x80. Required: 0x80 is unchanged on readback; M_icode = 1; m_stall deasserts the next cycle.
5. rst_n pulsed low mid-access. Required: all outputs take their reset values asynchronously and no write commits. Then MEM_LAT = 1: a back-to-back sequence never asserts m_stall.
6. With MEM_ALIGN_CHECK_EN: rmmovq to 0x43 gives m_stat = 3 and no write. Without it: the write lands at bytes 0x43–0x4A.
